// File: rtl/mpc_constraint_slack_seq.sv
// Constraint-slack sequencer: reads bound e[i] from ROM, pairs it with streamed (G*u)[i]
// and emits saturated slack s[i] = e[i] - (G*u)[i] with a per-pass violation count.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; viol_count holds last pass result
// RD      | ROM read issued for current row
// LAT     | ROM data returns, captured into bound_r
// WAIT_GU | waiting for (G*u)[row] from upstream; slack computed on transfer
// OUT     | slack presented downstream until accepted
// DONE    | one-cycle end-of-pass pulse
module mpc_constraint_slack_seq #(
   parameter int DataWidth    = 20,
   parameter int AddressWidth = 3,
   parameter int NumRows      = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    idle,
   output logic                    done,
   output logic [AddressWidth-1:0] rom_address0,
   output logic                    rom_ce0,
   input  logic [DataWidth-1:0]    rom_q0,
   input  logic [DataWidth-1:0]    gu_data,
   input  logic                    gu_valid,
   output logic                    gu_ready,
   output logic [DataWidth-1:0]    slack_data,
   output logic                    slack_viol,
   output logic                    slack_valid,
   input  logic                    slack_ready,
   output logic [AddressWidth:0]   viol_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_LAT     = 3'd2,
      S_WAIT_GU = 3'd3,
      S_OUT     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [AddressWidth-1:0] LastRow  = AddressWidth'(NumRows - 1);
   localparam logic [AddressWidth-1:0] RowOne   = AddressWidth'(1);
   localparam logic [AddressWidth:0]   CountOne = (AddressWidth + 1)'(1);
   localparam logic [DataWidth-1:0]    SatMax   = {1'b0, {(DataWidth-1){1'b1}}};
   localparam logic [DataWidth-1:0]    SatMin   = {1'b1, {(DataWidth-1){1'b0}}};

   state_t                  state, state_nxt;
   logic [AddressWidth-1:0] row;
   logic [DataWidth-1:0]    bound_r;
   logic [DataWidth:0]      diff;
   logic [DataWidth-1:0]    sat;

   // One extra bit holds the exact difference; top two bits disagreeing means overflow.
   always_comb begin
      diff = {bound_r[DataWidth-1], bound_r} - {gu_data[DataWidth-1], gu_data};
      sat  = diff[DataWidth-1:0];
      if (diff[DataWidth] != diff[DataWidth-1]) begin
         sat = diff[DataWidth] ? SatMin : SatMax;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idle      = 1'b0;
      done      = 1'b0;
      rom_ce0   = 1'b0;
      gu_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            idle = 1'b1;
            if (start) state_nxt = S_RD;
         end
         S_RD: begin
            rom_ce0   = 1'b1;
            state_nxt = S_LAT;
         end
         S_LAT: state_nxt = S_WAIT_GU;
         S_WAIT_GU: begin
            gu_ready = 1'b1;
            if (gu_valid) state_nxt = S_OUT;
         end
         S_OUT: begin
            if (slack_ready) state_nxt = (row == LastRow) ? S_DONE : S_RD;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // row only moves on OUT->RD or at start, so it doubles as the held ROM address.
   assign rom_address0 = row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row         <= '0;
         bound_r     <= '0;
         slack_data  <= '0;
         slack_viol  <= 1'b0;
         slack_valid <= 1'b0;
         viol_count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  row        <= '0;
                  viol_count <= '0;
               end
            end
            S_LAT: bound_r <= rom_q0;
            S_WAIT_GU: begin
               if (gu_valid) begin
                  slack_data  <= sat;
                  slack_viol  <= sat[DataWidth-1];
                  slack_valid <= 1'b1;
                  if (sat[DataWidth-1]) viol_count <= viol_count + CountOne;
               end
            end
            S_OUT: begin
               if (slack_ready) begin
                  slack_valid <= 1'b0;
                  if (row != LastRow) row <= row + RowOne;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mpc_constraint_slack_seq.sv
// Directed table-driven bench for mpc_constraint_slack_seq with a behavioural bound ROM.
module tb_mpc_constraint_slack_seq;

   localparam int DW = 20;
   localparam int AW = 3;
   localparam int NR = 8;
   localparam int BUDGET = 600;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          idle, done, rom_ce0, gu_ready, slack_viol, slack_valid;
   logic [AW-1:0] rom_address0;
   logic [DW-1:0] rom_q0 = '0;
   logic [DW-1:0] gu_data = '0;
   logic          gu_valid = 1'b0;
   logic [DW-1:0] slack_data;
   logic          slack_ready = 1'b0;
   logic [AW:0]   viol_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] gu;
      logic [DW-1:0] s;
      logic          v;
   } vec_t;

   vec_t          tbl[3*NR];
   int            exp_cnt[3];
   logic [DW-1:0] rom[NR];

   mpc_constraint_slack_seq #(.DataWidth(DW), .AddressWidth(AW), .NumRows(NR)) dut (
      .clk(clk), .reset(reset), .start(start), .idle(idle), .done(done),
      .rom_address0(rom_address0), .rom_ce0(rom_ce0), .rom_q0(rom_q0),
      .gu_data(gu_data), .gu_valid(gu_valid), .gu_ready(gu_ready),
      .slack_data(slack_data), .slack_viol(slack_viol), .slack_valid(slack_valid),
      .slack_ready(slack_ready), .viol_count(viol_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_ce0) rom_q0 <= rom[rom_address0];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a rising edge; with do_start=0 the DUT must already be in RD.
   task automatic run_pass(input int p, input bit stall, input bit hold, input bit do_start,
                           input bit mid_pulse);
      int base;
      base = p * NR;
      if (do_start) begin
         start = 1'b1;
         tick();
         if (!hold) start = 1'b0;
      end
      fork
         begin : feeder
            int n_in;
            bit hs;
            int b;
            n_in = 0;
            for (int r = 0; r < NR; r++) begin
               if (stall) repeat ($urandom_range(0, 5)) tick();
               gu_data  = tbl[base+r].gu;
               gu_valid = 1'b1;
               b = 0;
               do begin
                  hs = gu_ready;
                  tick();
                  b++;
               end while (!hs && b < BUDGET);
               gu_valid = 1'b0;
               chk("gu_handshake", hs, 1);
               if (hs) n_in++;
            end
            chk("gu_transfers", n_in, NR);
         end
         begin : drain
            int n_out;
            int b;
            logic [DW-1:0] held;
            n_out = 0;
            slack_ready = !stall;
            for (int r = 0; r < NR; r++) begin
               b = 0;
               while (!slack_valid && b < BUDGET) begin
                  tick();
                  b++;
               end
               chk("slack_valid_wait", slack_valid, 1);
               if (stall) begin
                  held = slack_data;
                  repeat ($urandom_range(0, 5)) begin
                     tick();
                     chk("stall_valid_hold", slack_valid, 1);
                     chk("stall_data_hold", slack_data, held);
                  end
                  slack_ready = 1'b1;
               end
               chk("slack_data", slack_data, tbl[base+r].s);
               chk("slack_viol", slack_viol, tbl[base+r].v);
               if (slack_valid) n_out++;
               tick();
               if (stall) slack_ready = 1'b0;
               chk("slack_valid_drop", slack_valid, 0);
            end
            chk("slack_transfers", n_out, NR);
         end
         begin : watcher
            int n;
            int ai;
            bit seen;
            n = 0;
            ai = 0;
            seen = 1'b0;
            while (n < BUDGET) begin
               if (mid_pulse) start = (n == 10 || n == 20);
               if (rom_ce0) begin
                  chk("rom_address", rom_address0, ai);
                  ai++;
               end
               if (done) begin
                  seen = 1'b1;
                  break;
               end
               tick();
               n++;
            end
            if (mid_pulse) start = 1'b0;
            chk("done_seen", seen, 1);
            if (seen) begin
               chk("rom_reads", ai, NR);
               if (!stall) chk("done_latency", n, 4*NR);
               chk("viol_count", viol_count, exp_cnt[p]);
               tick();
               chk("done_width", done, 0);
               chk("idle_after_done", idle, 1);
               chk("viol_count_hold", viol_count, exp_cnt[p]);
               if (hold) begin
                  tick();
                  chk("restart_rd", rom_ce0, 1);
                  chk("restart_addr", rom_address0, 0);
                  chk("restart_count_clr", viol_count, 0);
               end
            end
         end
      join
   endtask

   initial begin
      for (int r = 0; r < NR; r++) begin
         rom[r] = (r % 2 == 0) ? 20'hA0000 : 20'h6487F;
         tbl[r]        = '{gu: 20'h00000, s: rom[r], v: (r % 2 == 0)};
         tbl[2*NR + r] = tbl[r];
      end
      tbl[NR+0] = '{gu: 20'h7FFFF, s: 20'h80000, v: 1'b1};
      tbl[NR+1] = '{gu: 20'h80000, s: 20'h7FFFF, v: 1'b0};
      tbl[NR+2] = '{gu: 20'h20000, s: 20'h80000, v: 1'b1};
      tbl[NR+3] = '{gu: 20'h00001, s: 20'h6487E, v: 1'b0};
      tbl[NR+4] = '{gu: 20'hFFFFF, s: 20'hA0001, v: 1'b1};
      tbl[NR+5] = '{gu: 20'hE4880, s: 20'h7FFFF, v: 1'b0};
      tbl[NR+6] = '{gu: 20'hA0001, s: 20'hFFFFF, v: 1'b1};
      tbl[NR+7] = '{gu: 20'h64880, s: 20'hFFFFF, v: 1'b1};
      exp_cnt = '{4, 5, 4};

      tick();
      tick();
      chk("rst_idle", idle, 1);
      chk("rst_done", done, 0);
      chk("rst_rom_ce0", rom_ce0, 0);
      chk("rst_gu_ready", gu_ready, 0);
      chk("rst_slack_valid", slack_valid, 0);
      chk("rst_slack_viol", slack_viol, 0);
      chk("rst_rom_address0", rom_address0, 0);
      chk("rst_slack_data", slack_data, 0);
      chk("rst_viol_count", viol_count, 0);
      #4 reset = 1'b1;
      tick();

      // plain pass with stray start pulses mid-pass
      run_pass(0, 1'b0, 1'b0, 1'b1, 1'b1);
      // saturation / boundary pass
      run_pass(1, 1'b0, 1'b0, 1'b1, 1'b0);
      // same data as pass 0 with random stalls on both sides
      run_pass(2, 1'b1, 1'b0, 1'b1, 1'b0);

      // abort with reset while row 3 waits in OUT
      gu_data     = '0;
      gu_valid    = 1'b1;
      slack_ready = 1'b0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 0; r < 4; r++) begin
         int b;
         b = 0;
         while (!slack_valid && b < BUDGET) begin
            tick();
            b++;
         end
         chk("abort_valid_wait", slack_valid, 1);
         if (r < 3) begin
            slack_ready = 1'b1;
            tick();
            slack_ready = 1'b0;
         end
      end
      chk("abort_row", rom_address0, 3);
      chk("abort_partial_count", viol_count, 2);
      #2 reset = 1'b0;
      #1;
      chk("abort_idle", idle, 1);
      chk("abort_slack_valid", slack_valid, 0);
      chk("abort_rom_ce0", rom_ce0, 0);
      chk("abort_count", viol_count, 0);
      gu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", done, 0);
      end
      #4 reset = 1'b1;
      tick();
      chk("abort_released_idle", idle, 1);
      run_pass(0, 1'b0, 1'b0, 1'b1, 1'b0);

      // start held high across two back-to-back passes
      run_pass(0, 1'b0, 1'b1, 1'b1, 1'b0);
      start = 1'b0;
      run_pass(1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
